// File: rtl/multicycle_controller.sv
// Sequences multi-cycle instructions (load/store, mul/div, jump/branch target, trap) for a simple core.
// Outputs are combinational from state and inputs; the state, cycle counter and trap cause are registered.
module multicycle_controller #(
   parameter int CNT_W       = 4,
   parameter int LSU_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inst_valid_i,
   input  logic             jump_inst_i,
   input  logic             branch_inst_i,
   input  logic             illegal_inst_i,
   input  logic             lsu_en_i,
   input  logic             lsu_done_i,
   input  logic             lsu_err_i,
   input  logic             muldiv_en_i,
   input  logic             muldiv_done_i,
   input  logic             comp_result_i,
   output logic [CNT_W-1:0] cycle_counter_o,
   output logic             rf_wen_o,
   output logic             retire_o,
   output logic             target_valid_o,
   output logic             stall_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      LSU_WAIT    = 3'd1,
      MULDIV_WAIT = 3'd2,
      TGT         = 3'd3,
      TRAP        = 3'd4
   } state_t;

   localparam logic [1:0]       CAUSE_ILLEGAL = 2'd0;
   localparam logic [1:0]       CAUSE_LSU_ERR = 2'd1;
   localparam logic [1:0]       CAUSE_LSU_TO  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TO_LAST       = CNT_W'(LSU_TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       cause_q;
   logic [1:0]       cause_nxt;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cause_q <= 2'd0;
      end else begin
         state   <= state_nxt;
         cause_q <= cause_nxt;
      end
   end

   // Counter restarts whenever the op ends; otherwise counts up and sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_nxt == IDLE || state_nxt == TRAP) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      cause_nxt      = cause_q;
      rf_wen_o       = 1'b0;
      retire_o       = 1'b0;
      target_valid_o = 1'b0;
      stall_o        = 1'b0;
      trap_o         = 1'b0;
      trap_cause_o   = 2'd0;
      case (state)
         IDLE: begin
            if (inst_valid_i) begin
               if (illegal_inst_i) begin
                  state_nxt = TRAP;
                  cause_nxt = CAUSE_ILLEGAL;
                  stall_o   = 1'b1;
               end else if (lsu_en_i) begin
                  state_nxt = LSU_WAIT;
                  stall_o   = 1'b1;
               end else if (muldiv_en_i) begin
                  state_nxt = MULDIV_WAIT;
                  stall_o   = 1'b1;
               end else if (jump_inst_i) begin
                  state_nxt = TGT;
                  rf_wen_o  = 1'b1;
                  stall_o   = 1'b1;
               end else if (branch_inst_i) begin
                  if (comp_result_i) begin
                     state_nxt = TGT;
                     stall_o   = 1'b1;
                  end else begin
                     retire_o  = 1'b1;
                  end
               end else begin
                  rf_wen_o = 1'b1;
                  retire_o = 1'b1;
               end
            end
         end
         LSU_WAIT: begin
            stall_o = 1'b1;
            if (inst_valid_i) begin
               if (lsu_err_i) begin
                  state_nxt = TRAP;
                  cause_nxt = CAUSE_LSU_ERR;
               end else if (lsu_done_i) begin
                  state_nxt = IDLE;
                  rf_wen_o  = 1'b1;
                  retire_o  = 1'b1;
                  stall_o   = 1'b0;
               end else if (cnt_q == TO_LAST) begin
                  state_nxt = TRAP;
                  cause_nxt = CAUSE_LSU_TO;
               end
            end
         end
         MULDIV_WAIT: begin
            stall_o = 1'b1;
            if (inst_valid_i && muldiv_done_i) begin
               state_nxt = IDLE;
               rf_wen_o  = 1'b1;
               retire_o  = 1'b1;
               stall_o   = 1'b0;
            end
         end
         TGT: begin
            if (inst_valid_i) begin
               state_nxt      = IDLE;
               target_valid_o = 1'b1;
               retire_o       = 1'b1;
            end
         end
         TRAP: begin
            state_nxt    = IDLE;
            trap_o       = 1'b1;
            trap_cause_o = cause_q;
            stall_o      = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cycle_counter_o = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs queued at drive time, compared after outputs settle.
module tb_multicycle_controller;

   typedef struct packed {
      logic v, ill, lsu, md, jmp, br, cmp, ldone, lerr, mdone;
   } stim_t;

   typedef struct packed {
      logic       rf, ret, tv, st, tr;
      logic [1:0] cause;
      logic [3:0] cnt;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inst_valid_i = 1'b0, jump_inst_i = 1'b0, branch_inst_i = 1'b0, illegal_inst_i = 1'b0;
   logic       lsu_en_i = 1'b0, lsu_done_i = 1'b0, lsu_err_i = 1'b0;
   logic       muldiv_en_i = 1'b0, muldiv_done_i = 1'b0, comp_result_i = 1'b0;
   logic [3:0] cycle_counter_o;
   logic       rf_wen_o, retire_o, target_valid_o, stall_o, trap_o;
   logic [1:0] trap_cause_o;

   int   checks = 0;
   int   errors = 0;
   obs_t sb[$];

   multicycle_controller #(.CNT_W(4), .LSU_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i), .jump_inst_i(jump_inst_i),
      .branch_inst_i(branch_inst_i), .illegal_inst_i(illegal_inst_i), .lsu_en_i(lsu_en_i),
      .lsu_done_i(lsu_done_i), .lsu_err_i(lsu_err_i), .muldiv_en_i(muldiv_en_i),
      .muldiv_done_i(muldiv_done_i), .comp_result_i(comp_result_i),
      .cycle_counter_o(cycle_counter_o), .rf_wen_o(rf_wen_o), .retire_o(retire_o),
      .target_valid_o(target_valid_o), .stall_o(stall_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
   );

   always #5 clk = ~clk;

   function automatic stim_t S(input logic v, ill, lsu, md, jmp, br, cmp, ldone, lerr, mdone);
      return '{v, ill, lsu, md, jmp, br, cmp, ldone, lerr, mdone};
   endfunction

   function automatic obs_t E(input logic rf, ret, tv, st, tr, input logic [1:0] cause, input int cnt);
      return '{rf, ret, tv, st, tr, cause, 4'(cnt)};
   endfunction

   function automatic obs_t sample();
      return '{rf_wen_o, retire_o, target_valid_o, stall_o, trap_o, trap_cause_o, cycle_counter_o};
   endfunction

   task automatic apply(input stim_t s);
      {inst_valid_i, illegal_inst_i, lsu_en_i, muldiv_en_i, jump_inst_i, branch_inst_i,
       comp_result_i, lsu_done_i, lsu_err_i, muldiv_done_i} = s;
   endtask

   // Drives one cycle's inputs after the falling edge and queues what the outputs must show.
   task automatic drive(input stim_t s, input obs_t e);
      @(negedge clk);
      apply(s);
      sb.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      obs_t got, exp_o;
      apply(S(0,0,0,0,0,0,0,0,0,0));
      rst_n = 1'b0;
      drive(S(0,0,0,0,0,0,0,0,0,0), E(0,0,0,0,0,2'd0,0));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL reset_state got %b exp %b", got, exp_o); end
      @(negedge clk);
      rst_n = 1'b1;
      // Instruction flags without inst_valid_i must do nothing.
      drive(S(0,0,0,0,1,0,0,0,0,0), E(0,0,0,0,0,2'd0,0));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL hold_jump got %b exp %b", got, exp_o); end
      drive(S(0,0,1,0,0,0,0,0,0,0), E(0,0,0,0,0,2'd0,0));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL hold_lsu got %b exp %b", got, exp_o); end
      drive(S(0,0,0,0,0,0,0,0,0,0), E(0,0,0,0,0,2'd0,0));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL hold_after got %b exp %b", got, exp_o); end
   endtask

   task automatic test_plain();
      obs_t got, exp_o;
      for (int i = 0; i < 3; i++) begin
         drive(S(1,0,0,0,0,0,0,0,0,0), E(1,1,0,0,0,2'd0,0));
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL plain cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_load_done();
      stim_t st[$]; obs_t ex[$]; obs_t got, exp_o;
      st.push_back(S(1,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,0));
      st.push_back(S(1,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,1));
      st.push_back(S(1,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,2));
      st.push_back(S(1,0,1,0,0,0,0,1,0,0)); ex.push_back(E(1,1,0,0,0,2'd0,3));
      st.push_back(S(0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i], ex[i]);
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL load_done cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_load_timeout();
      stim_t st[$]; obs_t ex[$]; obs_t got, exp_o;
      for (int i = 0; i < 8; i++) begin
         st.push_back(S(1,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,i));
      end
      st.push_back(S(1,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,1,2'd2,0));
      st.push_back(S(0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i], ex[i]);
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL load_timeout cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_lsu_err();
      stim_t st[$]; obs_t ex[$]; obs_t got, exp_o;
      st.push_back(S(1,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,0));
      st.push_back(S(1,0,1,0,0,0,0,1,1,0)); ex.push_back(E(0,0,0,1,0,2'd0,1));
      st.push_back(S(1,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,1,2'd1,0));
      st.push_back(S(0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i], ex[i]);
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL lsu_err cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_branch_jump();
      stim_t st[$]; obs_t ex[$]; obs_t got, exp_o;
      st.push_back(S(1,0,0,0,0,1,1,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,0));
      st.push_back(S(1,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0,0,2'd0,1));
      st.push_back(S(1,0,0,0,0,1,0,0,0,0)); ex.push_back(E(0,1,0,0,0,2'd0,0));
      st.push_back(S(1,0,0,0,0,0,0,0,0,0)); ex.push_back(E(1,1,0,0,0,2'd0,0));
      st.push_back(S(1,0,0,0,1,1,0,0,0,0)); ex.push_back(E(1,0,0,1,0,2'd0,0));
      st.push_back(S(0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,1));
      st.push_back(S(1,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,1,0,0,2'd0,2));
      st.push_back(S(0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i], ex[i]);
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL branch_jump cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_priority();
      stim_t st[$]; obs_t ex[$]; obs_t got, exp_o;
      // Illegal beats everything; the trap cycle ignores inst_valid_i.
      st.push_back(S(1,1,1,1,1,1,1,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,0));
      st.push_back(S(0,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,1,2'd0,0));
      st.push_back(S(0,0,1,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,0));
      // Load beats mul/div: muldiv_done_i must not complete it.
      st.push_back(S(1,0,1,1,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,0));
      st.push_back(S(1,0,1,1,0,0,0,0,0,1)); ex.push_back(E(0,0,0,1,0,2'd0,1));
      st.push_back(S(1,0,1,1,0,0,0,1,0,0)); ex.push_back(E(1,1,0,0,0,2'd0,2));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i], ex[i]);
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL priority cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_muldiv_sat();
      stim_t st[$]; obs_t ex[$]; obs_t got, exp_o;
      st.push_back(S(1,0,0,1,0,0,0,0,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,0));
      for (int i = 1; i <= 20; i++) begin
         st.push_back(S(1,0,0,1,0,0,0,1,0,0)); ex.push_back(E(0,0,0,1,0,2'd0,(i > 15) ? 15 : i));
      end
      st.push_back(S(1,0,0,1,0,0,0,0,0,1)); ex.push_back(E(1,1,0,0,0,2'd0,15));
      st.push_back(S(0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2'd0,0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i], ex[i]);
         got = sample(); exp_o = sb.pop_front(); checks++;
         if (got !== exp_o) begin errors++; $display("FAIL muldiv_sat cyc %0d got %b exp %b", i, got, exp_o); end
      end
   endtask

   task automatic test_reset_mid();
      obs_t got, exp_o;
      drive(S(1,0,1,0,0,0,0,0,0,0), E(0,0,0,1,0,2'd0,0));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL rmid_issue got %b exp %b", got, exp_o); end
      drive(S(1,0,1,0,0,0,0,0,0,0), E(0,0,0,1,0,2'd0,1));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL rmid_wait got %b exp %b", got, exp_o); end
      // Reset lands between edges; completion is offered but must be ignored.
      #1;
      apply(S(0,0,0,0,0,0,0,1,0,0));
      rst_n = 1'b0;
      sb.push_back(E(0,0,0,0,0,2'd0,0));
      #1;
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL rmid_async got %b exp %b", got, exp_o); end
      @(negedge clk);
      rst_n = 1'b1;
      drive(S(1,0,0,0,0,0,0,0,0,0), E(1,1,0,0,0,2'd0,0));
      got = sample(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL rmid_first got %b exp %b", got, exp_o); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_plain();
      test_load_done();
      test_load_timeout();
      test_lsu_err();
      test_branch_jump();
      test_priority();
      test_muldiv_sat();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
